// File: rtl/laser_cover_opt.sv
// Two-circle laser-coverage optimiser: loads NPTS points, then alternately
// re-places C1 and C2 by exhaustive grid scan until stable or MAX_ITER passes.
module laser_cover_opt #(
  parameter int  COORD_W  = 4,
  parameter int  NPTS     = 40,
  parameter int  LANES    = 4,
  parameter int  MAX_ITER = 8,
  localparam int CNT_W    = $clog2(NPTS + 1),
  localparam int R2_W     = 2 * COORD_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [R2_W-1:0]    r2_i,
  output logic [COORD_W-1:0] c1x_o,
  output logic [COORD_W-1:0] c1y_o,
  output logic [COORD_W-1:0] c2x_o,
  output logic [COORD_W-1:0] c2y_o,
  output logic [CNT_W-1:0]   best_cnt_o,
  output logic [7:0]         iter_cnt_o,
  output logic               done_o
);

  typedef enum logic [3:0] {
    S_LOAD, S_INIT_C1, S_CALC_C1, S_UPD_C1,
    S_INIT_C2, S_CALC_C2, S_UPD_C2, S_CHECK, S_DONE
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] c1x;
    logic [COORD_W-1:0] c1y;
    logic [COORD_W-1:0] c2x;
    logic [COORD_W-1:0] c2y;
  } centres_t;

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   best_q, best_d;
  logic [R2_W-1:0]    r2_q, r2_d;
  logic [COORD_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  centres_t           cen_q, cen_d, snap_q, snap_d, out_cen_q, out_cen_d;
  logic [CNT_W-1:0]   out_best_q, out_best_d;
  logic [7:0]         iter_q, iter_d, out_iter_q, out_iter_d;
  logic               done_q, done_d;

  logic [COORD_W-1:0] mem_x [NPTS];
  logic [COORD_W-1:0] mem_y [NPTS];

  logic               accept;
  logic [COORD_W-1:0] fix_x, fix_y;
  logic [CNT_W-1:0]   lane_hits;

  // Squares are formed at full 2*COORD_W width so the sum cannot overflow.
  function automatic logic covers(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                  input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy,
                                  input logic [R2_W-1:0] r2);
    logic [COORD_W-1:0]   dx, dy;
    logic [2*COORD_W-1:0] sx, sy;
    logic [R2_W-1:0]      d2;
    dx = (px >= cx) ? px - cx : cx - px;
    dy = (py >= cy) ? py - cy : cy - py;
    sx = {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
    sy = {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
    d2 = {1'b0, sx} + {1'b0, sy};
    return d2 <= r2;
  endfunction

  assign accept = (state_q == S_LOAD) && ready_q && in_valid_i;

  always_comb begin
    fix_x     = (state_q == S_CALC_C2) ? cen_q.c1x : cen_q.c2x;
    fix_y     = (state_q == S_CALC_C2) ? cen_q.c1y : cen_q.c2y;
    lane_hits = '0;
    for (int l = 0; l < LANES; l++) begin
      if (covers(mem_x[ptr_q + CNT_W'(l)], mem_y[ptr_q + CNT_W'(l)], cand_x_q, cand_y_q, r2_q) ||
          covers(mem_x[ptr_q + CNT_W'(l)], mem_y[ptr_q + CNT_W'(l)], fix_x, fix_y, r2_q))
        lane_hits = lane_hits + CNT_W'(1);
    end
  end

  // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    ptr_d      = ptr_q;
    acc_d      = acc_q;
    best_d     = best_q;
    r2_d       = r2_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    cen_d      = cen_q;
    snap_d     = snap_q;
    iter_d     = iter_q;
    out_cen_d  = out_cen_q;
    out_best_d = out_best_q;
    out_iter_d = out_iter_q;
    done_d     = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (load_cnt_q == '0) r2_d = r2_i;
          if (load_cnt_q == CNT_W'(NPTS - 1)) begin
            state_d    = S_INIT_C1;
            load_cnt_d = '0;
            iter_d     = '0;
          end else begin
            load_cnt_d = load_cnt_q + CNT_W'(1);
          end
        end
      end
      S_INIT_C1, S_INIT_C2: begin
        if (state_q == S_INIT_C1) snap_d = cen_q;
        cand_x_d = '0;
        cand_y_d = '0;
        best_d   = '0;
        ptr_d    = '0;
        acc_d    = '0;
        state_d  = (state_q == S_INIT_C1) ? S_CALC_C1 : S_CALC_C2;
      end
      S_CALC_C1, S_CALC_C2: begin
        acc_d = acc_q + lane_hits;
        if (ptr_q == CNT_W'(NPTS - LANES)) begin
          ptr_d   = '0;
          state_d = (state_q == S_CALC_C1) ? S_UPD_C1 : S_UPD_C2;
        end else begin
          ptr_d = ptr_q + CNT_W'(LANES);
        end
      end
      S_UPD_C1, S_UPD_C2: begin
        // >= lets a later candidate win ties.
        if (acc_q >= best_q) begin
          best_d = acc_q;
          if (state_q == S_UPD_C1) begin
            cen_d.c1x = cand_x_q;
            cen_d.c1y = cand_y_q;
          end else begin
            cen_d.c2x = cand_x_q;
            cen_d.c2y = cand_y_q;
          end
        end
        acc_d = '0;
        if (cand_x_q == '1 && cand_y_q == '1) begin
          state_d = (state_q == S_UPD_C1) ? S_INIT_C2 : S_CHECK;
        end else begin
          if (cand_x_q == '1) begin
            cand_x_d = '0;
            cand_y_d = cand_y_q + 1'b1;
          end else begin
            cand_x_d = cand_x_q + 1'b1;
          end
          state_d = (state_q == S_UPD_C1) ? S_CALC_C1 : S_CALC_C2;
        end
      end
      S_CHECK: begin
        iter_d  = iter_q + 8'd1;
        state_d = ((cen_q == snap_q) || (iter_d == 8'(MAX_ITER))) ? S_DONE : S_INIT_C1;
      end
      S_DONE: begin
        out_cen_d  = cen_q;
        out_best_d = best_q;
        out_iter_d = iter_q;
        done_d     = 1'b1;
        cen_d      = '0;
        state_d    = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign ready_d = (state_d == S_LOAD);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      ready_q    <= 1'b0;
      load_cnt_q <= '0;
      ptr_q      <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      r2_q       <= '0;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      cen_q      <= '0;
      snap_q     <= '0;
      iter_q     <= '0;
      out_cen_q  <= '0;
      out_best_q <= '0;
      out_iter_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      load_cnt_q <= load_cnt_d;
      ptr_q      <= ptr_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      r2_q       <= r2_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      cen_q      <= cen_d;
      snap_q     <= snap_d;
      iter_q     <= iter_d;
      out_cen_q  <= out_cen_d;
      out_best_q <= out_best_d;
      out_iter_q <= out_iter_d;
      done_q     <= done_d;
    end
  end

  // NOTE: point storage has no reset; the load counter alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_x[load_cnt_q] <= x_i;
      mem_y[load_cnt_q] <= y_i;
    end
  end

  assign in_ready_o = ready_q;
  assign c1x_o      = out_cen_q.c1x;
  assign c1y_o      = out_cen_q.c1y;
  assign c2x_o      = out_cen_q.c2x;
  assign c2y_o      = out_cen_q.c2y;
  assign best_cnt_o = out_best_q;
  assign iter_cnt_o = out_iter_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_laser_cover_opt.sv
// Directed scoreboard bench for laser_cover_opt: instance A uses defaults,
// instance B caps the search at one iteration pair.
module tb_laser_cover_opt;

  typedef struct packed {
    logic [3:0] c1x;
    logic [3:0] c1y;
    logic [3:0] c2x;
    logic [3:0] c2y;
    logic [5:0] best;
    logic [7:0] iter;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid_a = 1'b0;
  logic       in_valid_b = 1'b0;
  logic [3:0] x = '0;
  logic [3:0] y = '0;
  logic [8:0] r2 = '0;

  logic       ready_a, ready_b, done_a, done_b;
  logic [3:0] c1x_a, c1y_a, c2x_a, c2y_a, c1x_b, c1y_b, c2x_b, c2y_b;
  logic [5:0] best_a, best_b;
  logic [7:0] iter_a, iter_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  res_t exp_a[$];
  res_t exp_b[$];
  logic [3:0] px_t [40];
  logic [3:0] py_t [40];

  laser_cover_opt dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_a), .in_ready_o(ready_a),
    .x_i(x), .y_i(y), .r2_i(r2),
    .c1x_o(c1x_a), .c1y_o(c1y_a), .c2x_o(c2x_a), .c2y_o(c2y_a),
    .best_cnt_o(best_a), .iter_cnt_o(iter_a), .done_o(done_a)
  );

  laser_cover_opt #(.MAX_ITER(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_b), .in_ready_o(ready_b),
    .x_i(x), .y_i(y), .r2_i(r2),
    .c1x_o(c1x_b), .c1y_o(c1y_b), .c2x_o(c2x_b), .c2y_o(c2y_b),
    .best_cnt_o(best_b), .iter_cnt_o(iter_b), .done_o(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic [3:0] c1x, input logic [3:0] c1y, input logic [3:0] c2x,
                              input logic [3:0] c2y, input logic [5:0] best, input logic [7:0] iter);
    res_t r;
    r = '{c1x, c1y, c2x, c2y, best, iter};
    return r;
  endfunction

  function automatic res_t get_res(input bit sel);
    res_t r;
    if (sel) r = '{c1x_b, c1y_b, c2x_b, c2y_b, best_b, iter_b};
    else     r = '{c1x_a, c1y_a, c2x_a, c2y_a, best_a, iter_a};
    return r;
  endfunction

  task automatic set_points(input logic [3:0] ax, input logic [3:0] ay, input int na,
                            input logic [3:0] bx, input logic [3:0] by);
    for (int i = 0; i < 40; i++) begin
      px_t[i] = (i < na) ? ax : bx;
      py_t[i] = (i < na) ? ay : by;
    end
  endtask

  // Drives 40 beats; with gaps set, IN_VALID drops pseudo-randomly and extra beats follow.
  task automatic load_job(input bit sel, input logic [8:0] r2v, input bit gaps);
    int  n = 0;
    int  guard = 0;
    bit  v;
    logic rdy;
    while (n < 40 && guard < 2000) begin
      @(negedge clk);
      guard++;
      v   = !(gaps && ($urandom_range(0, 2) == 0));
      x   = px_t[n];
      y   = py_t[n];
      r2  = r2v;
      in_valid_a = v && !sel;
      in_valid_b = v && sel;
      rdy = sel ? ready_b : ready_a;
      if (v && rdy === 1'b1) begin
        last_acc_cyc = cyc + 1;
        n++;
      end
    end
    if (n != 40) check("load_beats", n, 40);
    @(negedge clk);
    if (gaps) begin
      check("ready_drop", sel ? ready_b : ready_a, 0);
      x = 4'd0;
      y = 4'd0;
      for (int k = 0; k < 4; k++) @(negedge clk);
      check("ready_low_extra", sel ? ready_b : ready_a, 0);
    end
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string tag, output int lat);
    int   n = 0;
    res_t got;
    res_t e;
    while ((sel ? done_b : done_a) !== 1'b1 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - last_acc_cyc;
    check({tag, "_done"}, sel ? done_b : done_a, 1);
    got = get_res(sel);
    if (sel) begin
      check({tag, "_sb"}, exp_b.size(), 1);
      e = (exp_b.size() > 0) ? exp_b.pop_front() : '0;
    end else begin
      check({tag, "_sb"}, exp_a.size(), 1);
      e = (exp_a.size() > 0) ? exp_a.pop_front() : '0;
    end
    check({tag, "_c1x"},  got.c1x,  e.c1x);
    check({tag, "_c1y"},  got.c1y,  e.c1y);
    check({tag, "_c2x"},  got.c2x,  e.c2x);
    check({tag, "_c2y"},  got.c2y,  e.c2y);
    check({tag, "_best"}, got.best, e.best);
    check({tag, "_iter"}, got.iter, e.iter);
    @(negedge clk);
    check({tag, "_pulse"}, sel ? done_b : done_a, 0);
  endtask

  initial begin
    int lat;
    int dones;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready_a", ready_a, 0);
    check("rst_ready_b", ready_b, 0);
    check("rst_done_a",  done_a, 0);
    check("rst_res_a",   get_res(1'b0), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready_a", ready_a, 1);
    check("post_rst_ready_b", ready_b, 1);

    // All 40 points at (5,5), R2=16
    set_points(4'd5, 4'd5, 40, 4'd0, 4'd0);
    exp_a.push_back(mk(4'd5, 4'd9, 4'd15, 4'd15, 6'd40, 8'd2));
    load_job(1'b0, 9'd16, 1'b0);
    wait_done(1'b0, "same55", lat);

    // Two clusters, R2=0, single pass with exact latency
    set_points(4'd2, 4'd3, 20, 4'd12, 4'd13);
    exp_b.push_back(mk(4'd12, 4'd13, 4'd2, 4'd3, 6'd40, 8'd1));
    load_job(1'b1, 9'd0, 1'b0);
    wait_done(1'b1, "clus_cap1", lat);
    check("latency", lat, 5636);

    // Same clusters, converging run
    exp_a.push_back(mk(4'd12, 4'd13, 4'd2, 4'd3, 6'd40, 8'd2));
    load_job(1'b0, 9'd0, 1'b0);
    wait_done(1'b0, "clus", lat);

    // Same clusters with IN_VALID gaps and extra beats
    exp_a.push_back(mk(4'd12, 4'd13, 4'd2, 4'd3, 6'd40, 8'd2));
    load_job(1'b0, 9'd0, 1'b1);
    wait_done(1'b0, "clus_gaps", lat);

    // Radius-4 disc boundaries: last covering candidate lands on row 15
    set_points(4'd5, 4'd15, 40, 4'd0, 4'd0);
    exp_b.push_back(mk(4'd9, 4'd15, 4'd15, 4'd15, 6'd40, 8'd1));
    load_job(1'b1, 9'd16, 1'b0);
    wait_done(1'b1, "leg_4_0", lat);

    set_points(4'd5, 4'd14, 40, 4'd0, 4'd0);
    exp_b.push_back(mk(4'd8, 4'd15, 4'd15, 4'd15, 6'd40, 8'd1));
    load_job(1'b1, 9'd16, 1'b0);
    wait_done(1'b1, "leg_4_1", lat);

    set_points(4'd5, 4'd12, 40, 4'd0, 4'd0);
    exp_b.push_back(mk(4'd7, 4'd15, 4'd15, 4'd15, 6'd40, 8'd1));
    load_job(1'b1, 9'd16, 1'b0);
    wait_done(1'b1, "leg_2_3", lat);

    // Reset during CALC_C2 of the first pass aborts the job
    set_points(4'd5, 4'd5, 40, 4'd0, 4'd0);
    load_job(1'b0, 9'd16, 1'b0);
    for (int k = 0; k < 4000; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", ready_a, 0);
    check("abort_done",  done_a, 0);
    check("abort_res",   get_res(1'b0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_back", ready_a, 1);
    dones = 0;
    for (int k = 0; k < 7500; k++) begin
      @(negedge clk);
      if (done_a === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);

    // Fresh job after the abort
    exp_a.push_back(mk(4'd5, 4'd9, 4'd15, 4'd15, 6'd40, 8'd2));
    load_job(1'b0, 9'd16, 1'b0);
    wait_done(1'b0, "fresh", lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/laser_cover_opt.md
Name: laser_cover_opt

Overview:
- Parametrised two-circle laser-coverage optimiser; next generation of the fixed 4-bit / 40-point treatment engine.
- Streams in NPTS target points through a valid/ready handshake and samples a runtime squared radius.
- Alternately re-optimises circle C1 (C2 fixed), then C2 (C1 fixed), by exhaustive grid scan. Stops on convergence or an iteration cap.
- Reports both centres, covered-point count and iterations used. Sits between the point-source front end and the treatment controller.

Parameters:
- COORD_W, 4, coordinate width; grid is 0..2^COORD_W-1 on each axis.
- NPTS, 40, points per job; must be a multiple of LANES.
- LANES, 4, points tested per CALC cycle.
- MAX_ITER, 8, cap on C1+C2 iteration pairs; range 1..255.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  point beat valid.
- IN_READY  out  1  block accepts a point beat.
- X  in  COORD_W  point x.
- Y  in  COORD_W  point y.
- R2  in  2*COORD_W+1  squared radius; sampled on the first accepted beat of a job.
- C1X, C1Y, C2X, C2Y  out  COORD_W each  result centres.
- BEST_CNT  out  clog2(NPTS+1)  points covered by final C1∪C2.
- ITER_CNT  out  8  iteration pairs executed.
- DONE  out  1  one-cycle result strobe.

Behaviour:
- Reset (async, RST_N=0): all outputs 0 except IN_READY, which is also 0 during reset. State goes to LOAD; point count 0; internal best centres (0,0)/(0,0). A reset asserted mid-load or mid-compute aborts the job and discards any partial data.
- LOAD:
  - IN_READY=1. A beat is accepted when IN_VALID&IN_READY and is stored at the next index.
  - Gaps with IN_VALID=0 are not counted.
  - After the NPTS-th accepted beat: IN_READY drops the next cycle; go to INIT_C1; iteration counter = 0.
- Coverage test: point (px,py) is inside centre (cx,cy) iff dx²+dy² ≤ R2, where dx=|px−cx| and dy=|py−cy|.
  - Compute in 2*COORD_W+1 bits; no overflow permitted.
  - R2=16 reproduces the legacy radius-4 disc.
- INIT_C1: snapshot the old centres; candidate=(0,0); best count=0; lane pointer=0; accumulator=0.
- CALC_Cn:
  - Each cycle, add the number of the LANES points at the pointer that are inside the candidate OR inside the fixed circle.
  - Fixed circle is C2 for n=1, C1 for n=2.
  - Pointer advances by LANES; after NPTS/LANES cycles go to UPD_Cn.
- UPD_Cn:
  - If accumulator ≥ best: best=accumulator and Cn=candidate. Ties go to the later candidate.
  - Clear accumulator.
  - Scan order: x inner, y outer, from (0,0) to (max,max).
  - At (max,max): UPD_C1 → INIT_C2 and UPD_C2 → CHECK. Otherwise advance the candidate and return to CALC_Cn.
- INIT_C2: same as INIT_C1 without the snapshot.
- CHECK:
  - Increment the iteration counter.
  - Go to DONE if all four centres equal the snapshot or the counter = MAX_ITER; otherwise go to INIT_C1.
- DONE:
  - Register C1X..C2Y, BEST_CNT (final C2 best) and ITER_CNT.
  - Pulse DONE for exactly 1 cycle, then return to LOAD with best centres cleared to 0.
  - Outputs hold until the next DONE.
- Latency (LOAD end to DONE): per pass 2·(1+G²·(NPTS/LANES+1)) + 1 cycles, with G=2^COORD_W, plus 1 cycle for DONE. Defaults: 5635 cycles per pass.
- Beats presented while IN_READY=0 are ignored and must be held by the source.

Test Plan:
- Defaults, R2=16, all 40 points at (5,5) → DONE with C1=(5,9), C2=(15,15), BEST_CNT=40, ITER_CNT=2.
- R2=0, 20 points at (2,3) and 20 at (12,13) → C1=(12,13), C2=(2,3), BEST_CNT=40, ITER_CNT=2.
- Same stimulus as the previous scenario with MAX_ITER=1 → DONE after one pass, ITER_CNT=1.
- Also check exact cycle count from last accepted beat to DONE = 5635+1.
- IN_VALID toggled 1,0,0,1 pseudo-randomly during load → exactly 40 beats stored.
  - IN_READY falls after beat 40.
  - Extra IN_VALID beats are ignored.
  - Results match the gap-free run.
- RST_N pulsed low mid-CALC_C2 → outputs and IN_READY go to 0 immediately.
  - After release, IN_READY=1 and no DONE is produced.
  - A fresh 40-point job then completes correctly.
- Legacy equivalence, R2=16: point at offset (2,3) is inside, (3,3) is outside, (4,0) is inside, (4,1) is outside; verified by single-point jobs with BEST_CNT checks.
